// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
// Holds the opcode and state encodings, the slice control bundle and the
// slice mux select codes used by the decoder.

package alu_seq_pkg;

  // Operation codes as presented on the op input.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_SLT  = 3'd3,
    OP_AND  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_OR   = 3'd7
  } alu_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Slice mux select codes.
  localparam logic [2:0] SEL_SUM  = 3'd0;
  localparam logic [2:0] SEL_XOR  = 3'd2;
  localparam logic [2:0] SEL_NOR  = 3'd4;
  localparam logic [2:0] SEL_NAND = 3'd5;
  localparam logic [2:0] SEL_AND  = 3'd6;
  localparam logic [2:0] SEL_OR   = 3'd7;

  // Control bundle for one slice operation; cin0 is the carry into bit 0.
  typedef struct packed {
    logic [2:0] sel;
    logic       invta;
    logic       invtb;
    logic       cin0;
  } alu_ctl_t;

  // Only the adder-based operations report carry and overflow.
  function automatic logic op_has_flags(alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Opcode decoder for the bit-serial ALU sequencer.
// Purely combinational: maps an opcode onto the slice controls
// (mux select, operand inverts and the carry into bit 0).

module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  alu_op_t  i_op,
  output alu_ctl_t o_ctl
);

  // Table lookup; SUB and SLT both form a + ~b + 1 through the adder path.
  always_comb begin
    o_ctl = '0;
    case (i_op)
      OP_ADD:  o_ctl = '{sel: SEL_SUM,  invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
      OP_SUB:  o_ctl = '{sel: SEL_SUM,  invta: 1'b0, invtb: 1'b1, cin0: 1'b1};
      OP_XOR:  o_ctl = '{sel: SEL_XOR,  invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
      OP_SLT:  o_ctl = '{sel: SEL_SUM,  invta: 1'b0, invtb: 1'b1, cin0: 1'b1};
      OP_AND:  o_ctl = '{sel: SEL_AND,  invta: 1'b1, invtb: 1'b1, cin0: 1'b0};
      OP_NAND: o_ctl = '{sel: SEL_NAND, invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
      OP_NOR:  o_ctl = '{sel: SEL_NOR,  invta: 1'b0, invtb: 1'b0, cin0: 1'b0};
      OP_OR:   o_ctl = '{sel: SEL_OR,   invta: 1'b1, invtb: 1'b1, cin0: 1'b0};
      default: o_ctl = '0;
    endcase
  end

endmodule

// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer around an external 1-bit ALU slice.
// Accepts a WIDTH-bit operation, feeds the slice one bit pair per cycle
// (LSB first) with the carry looped back, collects the result bits and
// presents result plus flags on a valid/ready output.
// Optional build macro ALU_SEQ_PERF_CNT_EN adds the op_count output, a
// 32-bit count of completed result handshakes.

module alu_bitserial_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             sl_a,
  output logic             sl_b,
  output logic             sl_cin,
  output logic [2:0]       sl_sel,
  output logic             sl_invta,
  output logic             sl_invtb,
  input  logic             sl_result,
  input  logic             sl_cout,
  input  logic             sl_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      op_count
`endif
);

  localparam int IDXW = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  seq_state_t       r_state;
  seq_state_t       w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  alu_op_t          r_op;
  logic [2:0]       r_sel;
  logic             r_invta;
  logic             r_invtb;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_result;
  logic             r_carryout;
  logic             r_overflow;
  logic             r_zero;

  alu_ctl_t         w_ctl;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_flags_en;
  logic [WIDTH-1:0] w_result_final;

  alu_seq_decode u_decode (
    .i_op  (alu_op_t'(op)),
    .o_ctl (w_ctl)
  );

  assign w_run      = (r_state == RUN);
  assign w_accept   = (r_state == IDLE) && in_valid;
  assign w_last     = w_run && (r_idx == LAST_IDX);
  assign w_flags_en = op_has_flags(r_op);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (r_idx == LAST_IDX) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Merge the current slice bit into the result; SLT replaces the whole
  // word with the sign of the difference corrected for overflow.
  always_comb begin
    w_result_final        = r_result;
    w_result_final[r_idx] = sl_result;
    if (w_last && (r_op == OP_SLT)) begin
      w_result_final = {{(WIDTH-1){1'b0}}, sl_result ^ sl_overflow};
    end
  end

  // Operand capture at accept, then one bit per cycle while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_ADD;
      r_sel      <= '0;
      r_invta    <= 1'b0;
      r_invtb    <= 1'b0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_result   <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_accept) begin
      r_a        <= a;
      r_b        <= b;
      r_op       <= alu_op_t'(op);
      r_sel      <= w_ctl.sel;
      r_invta    <= w_ctl.invta;
      r_invtb    <= w_ctl.invtb;
      r_carry    <= w_ctl.cin0;
      r_idx      <= '0;
      r_result   <= '0;
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_run) begin
      r_result <= w_result_final;
      r_carry  <= sl_cout;
      if (w_last) begin
        r_carryout <= w_flags_en & sl_cout;
        r_overflow <= w_flags_en & sl_overflow;
        r_zero     <= (w_result_final == '0);
      end else begin
        r_idx <= r_idx + IDXW'(1);
      end
    end
  end

  // Slice data inputs are only live while running; controls hold their
  // last latched values so the slice sees no glitching select.
  assign sl_a     = w_run ? r_a[r_idx] : 1'b0;
  assign sl_b     = w_run ? r_b[r_idx] : 1'b0;
  assign sl_cin   = w_run ? r_carry    : 1'b0;
  assign sl_sel   = r_sel;
  assign sl_invta = r_invta;
  assign sl_invtb = r_invtb;

  assign result   = r_result;
  assign carryout = r_carryout;
  assign overflow = r_overflow;
  assign zero     = r_zero;

`ifdef ALU_SEQ_PERF_CNT_EN
  logic [31:0] r_op_count;

  // Count completed result handshakes; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= '0;
    end else if ((r_state == DONE) && out_ready) begin
      r_op_count <= r_op_count + 32'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Self-checking bench for alu_bitserial_seq with a behavioural 1-bit slice.
// The slice inverts only feed the adder path; logic functions use raw bits.

module tb_alu_bitserial_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sl_a, sl_b, sl_cin, sl_invta, sl_invtb;
  logic [2:0]       sl_sel;
  logic             sl_result, sl_cout, sl_overflow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout, overflow, zero;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [31:0]      opCount;
`endif

  int checks   = 0;
  int failures = 0;

  alu_bitserial_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .sl_a        (sl_a),
    .sl_b        (sl_b),
    .sl_cin      (sl_cin),
    .sl_sel      (sl_sel),
    .sl_invta    (sl_invta),
    .sl_invtb    (sl_invtb),
    .sl_result   (sl_result),
    .sl_cout     (sl_cout),
    .sl_overflow (sl_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .carryout    (carryout),
    .overflow    (overflow),
    .zero        (zero)
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    .op_count    (opCount)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model of the external 1-bit ALU slice.
  logic ea, eb, sum, co;
  always_comb begin
    ea  = sl_a ^ sl_invta;
    eb  = sl_b ^ sl_invtb;
    sum = ea ^ eb ^ sl_cin;
    co  = (ea & eb) | (ea & sl_cin) | (eb & sl_cin);
    case (sl_sel)
      3'd0:    sl_result = sum;
      3'd2:    sl_result = sl_a ^ sl_b;
      3'd4:    sl_result = ~(sl_a | sl_b);
      3'd5:    sl_result = ~(sl_a & sl_b);
      3'd6:    sl_result = sl_a & sl_b;
      3'd7:    sl_result = sl_a | sl_b;
      default: sl_result = 1'b0;
    endcase
    sl_cout     = co;
    sl_overflow = sl_cin ^ co;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present one op, then wait (bounded) for out_valid; cycles counts the
  // accept edge as cycle 1.
  task automatic runOp(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int cycles);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cycles = 1;
    while (!out_valid && cycles < WIDTH + 8) begin
      tick();
      cycles++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL op_timeout got out_valid=%b exp=1 after %0d cycles", out_valid, cycles);
    end
  endtask

  task automatic finishOp();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'h0) begin failures++; $display("[TB] FAIL rst_result got=%h exp=0", result); end
    checks++; if ({carryout, overflow, zero} !== 3'b000) begin failures++; $display("[TB] FAIL rst_flags got=%b exp=000", {carryout, overflow, zero}); end
    checks++; if ({sl_a, sl_b, sl_cin, sl_sel, sl_invta, sl_invtb} !== 8'h00) begin failures++; $display("[TB] FAIL rst_slice got=%h exp=00", {sl_a, sl_b, sl_cin, sl_sel, sl_invta, sl_invtb}); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int n;
    op = 3'd0; a = 32'h5; b = 32'h3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if ({sl_a, sl_b, sl_cin} !== 3'b110) begin failures++; $display("[TB] FAIL add_bit0_slice got=%b exp=110", {sl_a, sl_b, sl_cin}); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL add_run_in_ready got=%b exp=0", in_ready); end
    for (n = 1; n < 32; n++) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_early_valid got=%b exp=0 at cycle 32", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_latency got=%b exp=1 at cycle 33", out_valid); end
    checks++; if (result !== 32'h8) begin failures++; $display("[TB] FAIL add_result got=%h exp=00000008", result); end
    checks++; if ({carryout, overflow, zero} !== 3'b000) begin failures++; $display("[TB] FAIL add_flags got=%b exp=000", {carryout, overflow, zero}); end
    checks++; if ({sl_a, sl_b, sl_cin} !== 3'b000) begin failures++; $display("[TB] FAIL add_done_slice got=%b exp=000", {sl_a, sl_b, sl_cin}); end
    finishOp();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("[TB] FAIL add_handshake got=%b exp=01", {out_valid, in_ready}); end
  endtask

  task automatic test_sub_slt();
    int cyc;
    runOp(3'd1, 32'h8000_0000, 32'h1, cyc);
    checks++; if (result !== 32'h7FFF_FFFF) begin failures++; $display("[TB] FAIL sub_result got=%h exp=7fffffff", result); end
    checks++; if ({carryout, overflow, zero} !== 3'b110) begin failures++; $display("[TB] FAIL sub_flags got=%b exp=110", {carryout, overflow, zero}); end
    finishOp();
    runOp(3'd3, 32'h8000_0000, 32'h1, cyc);
    checks++; if (result !== 32'h1) begin failures++; $display("[TB] FAIL slt_result got=%h exp=00000001", result); end
    checks++; if ({carryout, overflow, zero} !== 3'b110) begin failures++; $display("[TB] FAIL slt_flags got=%b exp=110", {carryout, overflow, zero}); end
    finishOp();
    runOp(3'd3, 32'h5, 32'h7, cyc);
    checks++; if (result !== 32'h1) begin failures++; $display("[TB] FAIL slt_pos_result got=%h exp=00000001", result); end
    finishOp();
    runOp(3'd3, 32'h7, 32'h5, cyc);
    checks++; if ({result, zero} !== {32'h0, 1'b1}) begin failures++; $display("[TB] FAIL slt_false got=%h/%b exp=00000000/1", result, zero); end
    finishOp();
  endtask

  task automatic test_logic();
    int cyc;
    logic [2:0]  opv [5];
    logic [31:0] expv [5];
    opv  = '{3'd4, 3'd7, 3'd5, 3'd6, 3'd2};
    expv = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FFF_0FFF, 32'h000F_000F, 32'h0FF0_0FF0};
    for (int i = 0; i < 5; i++) begin
      runOp(opv[i], 32'hF0F0_F0F0, 32'hFF00_FF00, cyc);
      checks++; if (result !== expv[i]) begin failures++; $display("[TB] FAIL logic_result op=%0d got=%h exp=%h", opv[i], result, expv[i]); end
      checks++; if ({carryout, overflow, zero} !== 3'b000) begin failures++; $display("[TB] FAIL logic_flags op=%0d got=%b exp=000", opv[i], {carryout, overflow, zero}); end
      finishOp();
    end
  endtask

  task automatic test_wrap();
    int cyc;
    runOp(3'd0, 32'hFFFF_FFFF, 32'h1, cyc);
    checks++; if (result !== 32'h0) begin failures++; $display("[TB] FAIL wrap_result got=%h exp=00000000", result); end
    checks++; if ({carryout, overflow, zero} !== 3'b101) begin failures++; $display("[TB] FAIL wrap_flags got=%b exp=101", {carryout, overflow, zero}); end
    finishOp();
  endtask

  task automatic test_backpressure();
    int cyc;
    runOp(3'd2, 32'h1234_5678, 32'h0F0F_0F0F, cyc);
    op = 3'd0; a = 32'h1; b = 32'h1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({out_valid, in_ready, result} !== {2'b10, 32'h1D3B_5977}) begin failures++; $display("[TB] FAIL bp_hold cyc=%0d got=%b%b/%h exp=10/1d3b5977", i, out_valid, in_ready, result); end
    end
    checks++; if (sl_sel !== 3'd2) begin failures++; $display("[TB] FAIL bp_sel_hold got=%0d exp=2", sl_sel); end
    in_valid = 1'b0;
    finishOp();
    tick();
    tick();
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("[TB] FAIL bp_no_queue got=%b exp=01", {out_valid, in_ready}); end
  endtask

  task automatic test_reset_abort();
    int cyc;
    op = 3'd0; a = 32'hFFFF_FFFF; b = 32'h0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("[TB] FAIL abort_run_async got=%b exp=01", {out_valid, in_ready}); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if ({out_valid, in_ready, result} !== {2'b01, 32'h0}) begin failures++; $display("[TB] FAIL abort_run_idle got=%b%b/%h exp=01/00000000", out_valid, in_ready, result); end
    runOp(3'd0, 32'h1, 32'h1, cyc);
    checks++; if (result !== 32'h2) begin failures++; $display("[TB] FAIL abort_next_add got=%h exp=00000002", result); end
    rst = 1'b1;
    #1;
    checks++; if ({out_valid, in_ready, result} !== {2'b01, 32'h0}) begin failures++; $display("[TB] FAIL abort_done_async got=%b%b/%h exp=01/00000000", out_valid, in_ready, result); end
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef ALU_SEQ_PERF_CNT_EN
  task automatic test_perf_count();
    int cyc;
    doReset();
    checks++; if (opCount !== 32'd0) begin failures++; $display("[TB] FAIL perf_reset got=%0d exp=0", opCount); end
    for (int i = 0; i < 3; i++) begin
      runOp(3'd0, 32'(i), 32'h1, cyc);
      finishOp();
    end
    checks++; if (opCount !== 32'd3) begin failures++; $display("[TB] FAIL perf_count got=%0d exp=3", opCount); end
  endtask
`endif

  // Hard time limit so a stuck design still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = '0; b = '0;
    test_reset();
    test_add();
    test_sub_slt();
    test_logic();
    test_wrap();
    test_backpressure();
    test_reset_abort();
`ifdef ALU_SEQ_PERF_CNT_EN
    test_perf_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
